// File: rtl/score_streamer_if.sv
`default_nettype none
// ============================================================================
// Module   : score_streamer_if
// Brief    : Accumulator-in / score-out bundle for score_streamer.
// Revision : 1.0
// ============================================================================
interface score_streamer_if #(
  parameter int ACC_W = 24
);
  logic                    acc_valid;
  logic signed [ACC_W-1:0] acc_in;
  logic                    abort;
  logic                    valid_out;
  logic signed [11:0]      data_out;
  logic                    frame_done;
  logic                    busy;
  logic                    overrun;

  modport master (
    output acc_valid, acc_in, abort,
    input  valid_out, data_out, frame_done, busy, overrun
  );

  modport slave (
    input  acc_valid, acc_in, abort,
    output valid_out, data_out, frame_done, busy, overrun
  );
endinterface
`default_nettype wire

// File: rtl/score_streamer.sv
`default_nettype none
// ============================================================================
// Module   : score_streamer
// Brief    : Buffers one frame of shifted class scores, then streams it out.
//            Define SCORE_SAT_EN to clamp scores instead of wrapping them.
// Revision : 1.0
// ============================================================================
module score_streamer #(
  parameter int ACC_W   = 24,
  parameter int SHIFT   = 8,
  parameter int N_CLASS = 10
) (
  input  logic            clk,
  input  logic            rst_n,
  score_streamer_if.slave bus
);
  localparam int IDX_W = (N_CLASS > 1) ? $clog2(N_CLASS) : 1;
  localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(N_CLASS - 1);

  typedef enum logic [1:0] {
    S_FILL = 2'd0,
    S_SEND = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [IDX_W-1:0]   r_wr_idx, w_wr_idx_nxt;
  logic [IDX_W-1:0]   r_rd_idx, w_rd_idx_nxt;
  logic               r_valid, w_valid_nxt;
  logic               r_done, w_done_nxt;
  logic               r_overrun, w_overrun_nxt;
  logic signed [11:0] r_data, w_data_nxt;
  logic signed [11:0] r_buf [N_CLASS];
  logic               w_cap;
  logic signed [11:0] w_score;

`ifdef SCORE_SAT_EN
  localparam logic signed [ACC_W-1:0] c_max = ACC_W'(2047);
  localparam logic signed [ACC_W-1:0] c_min = ACC_W'(-2048);
  logic signed [ACC_W-1:0] w_shift;

  assign w_shift = bus.acc_in >>> SHIFT;

  always_comb begin
    if (w_shift > c_max)      w_score = 12'h7FF;
    else if (w_shift < c_min) w_score = 12'h800;
    else                      w_score = w_shift[11:0];
  end
`else
  assign w_score = 12'(bus.acc_in >>> SHIFT);
`endif

  always_comb begin
    w_state_nxt   = r_state;
    w_wr_idx_nxt  = r_wr_idx;
    w_rd_idx_nxt  = r_rd_idx;
    w_valid_nxt   = 1'b0;
    w_done_nxt    = 1'b0;
    w_data_nxt    = r_data;
    w_overrun_nxt = r_overrun;
    w_cap         = 1'b0;
    // abort beats everything, including a same-cycle sample and the overrun flag
    if (bus.abort) begin
      w_state_nxt  = S_FILL;
      w_wr_idx_nxt = '0;
      w_rd_idx_nxt = '0;
    end else begin
      case (r_state)
        S_FILL: begin
          if (bus.acc_valid) begin
            w_cap = 1'b1;
            if (r_wr_idx == c_last_idx) begin
              w_state_nxt  = S_SEND;
              w_wr_idx_nxt = '0;
              w_rd_idx_nxt = '0;
              w_valid_nxt  = 1'b1;
              w_data_nxt   = (N_CLASS == 1) ? w_score : r_buf[0];
            end else begin
              w_wr_idx_nxt = r_wr_idx + 1'b1;
            end
          end
        end
        S_SEND: begin
          w_overrun_nxt = r_overrun | bus.acc_valid;
          if (r_rd_idx == c_last_idx) begin
            w_state_nxt  = S_DONE;
            w_done_nxt   = 1'b1;
            w_rd_idx_nxt = '0;
          end else begin
            w_rd_idx_nxt = r_rd_idx + 1'b1;
            w_valid_nxt  = 1'b1;
            w_data_nxt   = r_buf[w_rd_idx_nxt];
          end
        end
        S_DONE: begin
          w_overrun_nxt = r_overrun | bus.acc_valid;
          w_state_nxt   = S_FILL;
        end
        default: w_state_nxt = S_FILL;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_FILL;
      r_wr_idx  <= '0;
      r_rd_idx  <= '0;
      r_valid   <= 1'b0;
      r_done    <= 1'b0;
      r_overrun <= 1'b0;
      r_data    <= '0;
      for (int i = 0; i < N_CLASS; i++) r_buf[i] <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_wr_idx  <= w_wr_idx_nxt;
      r_rd_idx  <= w_rd_idx_nxt;
      r_valid   <= w_valid_nxt;
      r_done    <= w_done_nxt;
      r_overrun <= w_overrun_nxt;
      r_data    <= w_data_nxt;
      if (w_cap) r_buf[r_wr_idx] <= w_score;
    end
  end

  assign bus.valid_out  = r_valid;
  assign bus.data_out   = r_data;
  assign bus.frame_done = r_done;
  assign bus.busy       = (r_state != S_FILL);
  assign bus.overrun    = r_overrun;
endmodule
`default_nettype wire

// File: tb/tb_score_streamer.sv
`default_nettype none
// ============================================================================
// Module   : tb_score_streamer
// Brief    : Directed self-checking bench for score_streamer.
// Revision : 1.0
// ============================================================================
module tb_score_streamer;
  localparam int ACC_W = 24;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   errs  = 0;
  int   checks = 0;

  logic [ACC_W-1:0] in_v  [10];
  int               exp_v [10];

  score_streamer_if #(.ACC_W(ACC_W)) bus ();

  score_streamer #(
    .ACC_W  (ACC_W),
    .SHIFT  (8),
    .N_CLASS(10)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [31:0] act, input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lin(input int base, input int step);
    for (int i = 0; i < 10; i++) begin
      exp_v[i] = base + step * i;
      in_v[i]  = ACC_W'((base + step * i) * 256);
    end
  endtask

  task automatic feed(input int n);
    for (int i = 0; i < n; i++) begin
      bus.acc_valid = 1'b1;
      bus.acc_in    = in_v[i];
      tick();
    end
    bus.acc_valid = 1'b0;
  endtask

  // Called in the first SEND cycle; ends in the FILL cycle after DONE.
  task automatic expect_stream(input string tag, input int inj);
    for (int i = 0; i < 10; i++) begin
      check($sformatf("%s_valid%0d", tag, i), {31'd0, bus.valid_out}, 1);
      check($sformatf("%s_data%0d", tag, i), 32'($signed(bus.data_out)), exp_v[i]);
      if (i == 0) check($sformatf("%s_busy", tag), {31'd0, bus.busy}, 1);
      if (i == inj) begin
        bus.acc_valid = 1'b1;
        bus.acc_in    = 24'h0FFF00;
      end
      tick();
      bus.acc_valid = 1'b0;
    end
    check($sformatf("%s_done", tag),       {31'd0, bus.frame_done}, 1);
    check($sformatf("%s_done_valid", tag), {31'd0, bus.valid_out}, 0);
    check($sformatf("%s_done_busy", tag),  {31'd0, bus.busy}, 1);
    tick();
    check($sformatf("%s_done_low", tag),   {31'd0, bus.frame_done}, 0);
    check($sformatf("%s_idle_busy", tag),  {31'd0, bus.busy}, 0);
  endtask

  initial begin
    bus.acc_valid = 1'b0;
    bus.acc_in    = '0;
    bus.abort     = 1'b0;
    tick();
    tick();
    check("rst_valid",   {31'd0, bus.valid_out}, 0);
    check("rst_data",    32'($signed(bus.data_out)), 0);
    check("rst_done",    {31'd0, bus.frame_done}, 0);
    check("rst_busy",    {31'd0, bus.busy}, 0);
    check("rst_overrun", {31'd0, bus.overrun}, 0);
    rst_n = 1'b1;

    // Scores 0..9 from k*256
    set_lin(0, 1);
    feed(10);
    expect_stream("lin", -1);
    check("hold_data", 32'($signed(bus.data_out)), 9);
    check("lin_overrun", {31'd0, bus.overrun}, 0);

    // Conversion extremes, floor rounding of negatives, 12-bit boundaries
    in_v = '{24'h7FFFFF, 24'h800000, 24'hFFFF00, 24'h0001FF, 24'hFFFFFF,
             24'hFFFE80, 24'h006400, 24'h07FF00, 24'h080000, 24'hF7F700};
`ifdef SCORE_SAT_EN
    exp_v = '{2047, -2048, -1, 1, -1, -2, 100, 2047, 2047, -2048};
`else
    exp_v = '{-1, 0, -1, 1, -1, -2, 100, 2047, -2048, 2039};
`endif
    feed(10);
    expect_stream("conv", -1);

    // Abort after 6 captures, colliding with a sample
    set_lin(99, 0);
    feed(6);
    bus.abort     = 1'b1;
    bus.acc_valid = 1'b1;
    bus.acc_in    = 24'(77 * 256);
    tick();
    bus.abort     = 1'b0;
    bus.acc_valid = 1'b0;
    check("abort_busy",    {31'd0, bus.busy}, 0);
    check("abort_valid",   {31'd0, bus.valid_out}, 0);
    check("abort_overrun", {31'd0, bus.overrun}, 0);
    set_lin(5, 0);
    feed(10);
    expect_stream("abort", -1);

    // Sample during beat 4 is dropped and flags overrun
    set_lin(0, 1);
    feed(10);
    expect_stream("ovr", 4);
    check("ovr_set", {31'd0, bus.overrun}, 1);
    tick();
    tick();
    check("ovr_sticky", {31'd0, bus.overrun}, 1);

    // Reset during beat 3
    set_lin(20, 1);
    feed(10);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("pre_rst_data%0d", i), 32'($signed(bus.data_out)), exp_v[i]);
      tick();
    end
    check("beat3_valid", {31'd0, bus.valid_out}, 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("mid_rst_valid",   {31'd0, bus.valid_out}, 0);
    check("mid_rst_data",    32'($signed(bus.data_out)), 0);
    check("mid_rst_done",    {31'd0, bus.frame_done}, 0);
    check("mid_rst_busy",    {31'd0, bus.busy}, 0);
    check("mid_rst_overrun", {31'd0, bus.overrun}, 0);
    set_lin(-3, 1);
    feed(10);
    expect_stream("post_rst", -1);

    // Back-to-back frames
    set_lin(10, 1);
    feed(10);
    expect_stream("b2b_a", -1);
    set_lin(30, 2);
    feed(10);
    expect_stream("b2b_b", -1);
    check("b2b_overrun", {31'd0, bus.overrun}, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/score_streamer.md
SCORE_STREAMER -- requirements
Module: score_streamer

Interface
REQ-001 Parameter: ACC_W, 24, signed accumulator input width.
REQ-002 Parameter: SHIFT, 8, arithmetic right-shift applied to each accumulator value.
REQ-003 Parameter: N_CLASS, 10, number of scores per frame.
REQ-004 Port: clk  input  1  clock; all logic on rising edge.
REQ-005 Port: rst_n  input  1  reset; synchronous, active-low.
REQ-006 Port: acc_valid  input  1  acc_in is valid this cycle.
REQ-007 Port: acc_in  input  ACC_W  signed class accumulator, arriving in class order 0..N_CLASS-1.
REQ-008 Port: abort  input  1  synchronous frame discard.
REQ-009 Port: valid_out  output  1  data_out is valid; drives the argmax stage's valid_in.
REQ-010 Port: data_out  output  12  signed score, class order.
REQ-011 Port: frame_done  output  1  single-cycle pulse after the last beat.
REQ-012 Port: busy  output  1  high in SEND and DONE.
REQ-013 Port: overrun  output  1  sticky; an input was dropped.

Function
REQ-014 The FSM SHALL have states FILL, SEND and DONE; reset state is FILL.
REQ-015 In FILL, each acc_valid SHALL capture one converted score into buf[wr_idx] and increment wr_idx.
REQ-016 Conversion SHALL be acc_in >>> SHIFT (arithmetic, floor), then reduced to 12 bits per REQ-029/REQ-030, at capture time.
REQ-017 Capture at wr_idx == N_CLASS-1 SHALL move to SEND on the next edge, with wr_idx cleared and rd_idx = 0.
REQ-018 In SEND, valid_out SHALL be 1 for exactly N_CLASS consecutive cycles with data_out = buf[0..N_CLASS-1], one entry per cycle; no gaps.
REQ-019 The first beat SHALL be registered in the cycle immediately after the final capture.
REQ-020 After the last beat, the FSM SHALL enter DONE for one cycle with frame_done = 1 and valid_out = 0, then return to FILL.
REQ-021 acc_valid in SEND or DONE SHALL be dropped and SHALL set overrun; buffer contents are unaffected.
REQ-022 abort SHALL force FILL, wr_idx = 0, rd_idx = 0, valid_out = 0 and frame_done = 0 on the next edge; overrun is unchanged.
REQ-023 When abort and acc_valid are both high, abort wins; the sample is discarded and overrun is not set.
REQ-024 busy SHALL be 1 exactly when the state is SEND or DONE.
REQ-025 data_out SHALL hold its last value while valid_out = 0.
REQ-026 Back-to-back frames SHALL be supported: the first capture of the next frame is accepted the cycle after DONE.

Reset
REQ-027 rst_n = 0 SHALL set the state to FILL, wr_idx = 0, rd_idx = 0, valid_out = 0, data_out = 0, frame_done = 0, busy = 0, overrun = 0 and all buf entries to 0.
REQ-028 Reset mid-SEND SHALL terminate the stream immediately, with valid_out = 0 on the cycle after the reset edge.

Configuration
REQ-029 With SCORE_SAT_EN defined, the shifted value SHALL clamp to [-2048, 2047].
REQ-030 Without SCORE_SAT_EN, the shifted value SHALL be truncated to bits [11:0] (two's-complement wrap).

Verification
REQ-031 Ten captures of acc_in = k*256 (k = 0..9), SHIFT = 8 -> valid_out high for 10 consecutive cycles starting the cycle after the 10th capture, data_out = 0..9, frame_done pulse on the next cycle.
REQ-032 acc_in = 0x7FFFFF and 0x800000 with SCORE_SAT_EN -> 2047 and -2048; without SCORE_SAT_EN -> 0xFFF and 0x000.
REQ-033 acc_valid asserted during beat 4 of SEND -> stream unchanged, overrun = 1 and remains 1 until reset.
REQ-034 abort after 6 captures, then 10 fresh captures of value 5*256 -> only the fresh frame is streamed, all beats = 5.
REQ-035 rst_n low during beat 3 -> valid_out = 0 on the next cycle, all outputs at reset values, next frame streams correctly.
REQ-036 Two frames back-to-back with continuous acc_valid except during busy -> 20 correct beats and two frame_done pulses.
